neuron_mac: RTL and testbench

Sequential multiply-accumulate neuron that computes one fixed-point weighted sum plus bias per packet of (activation, weight) beats. It sits directly upstream of the ReLu stage in the autoencoder datapath: its `result` feeds the ReLu `val` input, one neuron output per packet. Packets arrive over a valid/ready stream, and the output is held under a valid/ready handshake.

---
 rtl/autoencoder_pkg.sv | 30 +++
 rtl/fxp_mul.sv | 12 +
 rtl/neuron_mac.sv | 135 +++++++++++++
 tb/tb_neuron_mac.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/autoencoder_pkg.sv
// Shared definitions for the autoencoder datapath: fixed-point defaults,
// accumulator sizing, MAC state encoding and Q-format limits.
package autoencoder_pkg;

  localparam int NBITS_DEF   = 16;
  localparam int FRAC_DEF    = 8;
  localparam int MAX_LEN_DEF = 64;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } mac_state_e;

  localparam logic [NBITS_DEF-1:0] Q_MAX_DEF = {1'b0, {(NBITS_DEF-1){1'b1}}};
  localparam logic [NBITS_DEF-1:0] Q_MIN_DEF = {1'b1, {(NBITS_DEF-1){1'b0}}};

  // Headroom of clog2(max_len) bits keeps a full packet of products from overflowing.
  function automatic int acc_width(input int nbits, input int max_len);
    return 2 * nbits + $clog2(max_len);
  endfunction

  function automatic longint q_max(input int nbits);
    return (64'sd1 <<< (nbits - 1)) - 64'sd1;
  endfunction

  function automatic longint q_min(input int nbits);
    return -(64'sd1 <<< (nbits - 1));
  endfunction

endpackage

// File: rtl/fxp_mul.sv
// Combinational signed NBITS x NBITS -> 2*NBITS fixed-point multiplier.
module fxp_mul #(
  parameter int NBITS = 16
) (
  input  logic signed [NBITS-1:0]   a,
  input  logic signed [NBITS-1:0]   b,
  output logic signed [2*NBITS-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate neuron: weighted sum plus bias per packet.
// Define NEURON_MAC_SAT_EN to saturate the final NBITS reduction instead of wrapping.
module neuron_mac
  import autoencoder_pkg::*;
#(
  parameter int NBITS   = NBITS_DEF,
  parameter int FRAC    = FRAC_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_x,
  input  logic [NBITS-1:0] in_w,
  input  logic             in_last,
  input  logic [NBITS-1:0] bias,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] result,
  output logic             len_err
);

  localparam int ACCW = acc_width(NBITS, MAX_LEN);
  localparam int CNTW = $clog2(MAX_LEN);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAX_LEN - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  mac_state_e               state_q, state_d;
  logic signed [ACCW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic [NBITS-1:0]         result_q, result_d;
  logic                     len_err_q, len_err_d;

  logic signed [2*NBITS-1:0] prod_s;
  logic signed [ACCW-1:0]    prod_ext_s;
  logic signed [ACCW-1:0]    bias_ext_s;
  logic signed [ACCW-1:0]    sum_s;
  logic [NBITS-1:0]          reduced_s;
  logic                      last_s;

  fxp_mul #(.NBITS(NBITS)) u_mul (
    .a (in_x),
    .b (in_w),
    .p (prod_s)
  );

  assign prod_ext_s = {{(ACCW-2*NBITS){prod_s[2*NBITS-1]}}, prod_s};
  assign bias_ext_s = {{(ACCW-NBITS-FRAC){bias[NBITS-1]}}, bias, {FRAC{1'b0}}};
  assign sum_s      = acc_q + prod_ext_s + bias_ext_s;
  assign last_s     = in_last || (cnt_q == CNT_LAST);

`ifdef NEURON_MAC_SAT_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(q_max(NBITS));
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(q_min(NBITS));

  logic signed [ACCW-1:0] shifted_s;
  assign shifted_s = sum_s >>> FRAC;

  always_comb begin
    if (shifted_s > SAT_MAX) begin
      reduced_s = {1'b0, {(NBITS-1){1'b1}}};
    end else if (shifted_s < SAT_MIN) begin
      reduced_s = {1'b1, {(NBITS-1){1'b0}}};
    end else begin
      reduced_s = shifted_s[NBITS-1:0];
    end
  end
`else
  // Floor shift then wrap to NBITS is exactly this slice of the sum.
  assign reduced_s = sum_s[NBITS+FRAC-1:FRAC];
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    len_err_d = len_err_q;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          if (last_s) begin
            // Parking the final sum in acc is harmless: it is cleared on the handshake.
            acc_d     = sum_s;
            result_d  = reduced_s;
            state_d   = OUT;
            len_err_d = len_err_q | ~in_last;
          end else begin
            acc_d = acc_q + prod_ext_s;
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ACC;
        end
      end
      OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACC;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ACC;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      len_err_q <= len_err_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);
  assign result    = result_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed self-checking bench for neuron_mac (Q8.8, MAX_LEN=4).
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = 16'h0000;
  logic [15:0] in_w = 16'h0000;
  logic        in_last = 1'b0;
  logic [15:0] bias = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        len_err;

  int checks   = 0;
  int failures = 0;

  neuron_mac #(.NBITS(16), .FRAC(8), .MAX_LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .in_last   (in_last),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] w;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one beat and let it be clocked; returns on the following falling edge.
  task automatic beat(input logic [15:0] x, input logic [15:0] w, input logic last,
                      input logic [15:0] b);
    in_valid = 1'b1;
    in_x     = x;
    in_w     = w;
    in_last  = last;
    bias     = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_x     = 16'hDEAD;
    in_w     = 16'hBEEF;
    bias     = 16'h5A5A;
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{x: 16'h0200, w: 16'h0180, b: 16'h0100, exp: 16'h0400};
    vecs[1] = '{x: 16'hFF00, w: 16'h0200, b: 16'h0000, exp: 16'hFE00};
    vecs[2] = '{x: 16'h0080, w: 16'h0080, b: 16'h0000, exp: 16'h0040};
    vecs[3] = '{x: 16'h0001, w: 16'h0001, b: 16'h0000, exp: 16'h0000};
    vecs[4] = '{x: 16'hFFFF, w: 16'h0001, b: 16'h0000, exp: 16'hFFFF};
    vecs[5] = '{x: 16'h0000, w: 16'h1234, b: 16'hFF00, exp: 16'hFF00};

    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_result",    {16'd0, result},    32'd0);
    chk("rst_len_err",   {31'd0, len_err},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single-beat packets with out_ready held high: each result lives one cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("vec%0d_ready", i), {31'd0, in_ready}, 32'd1);
      beat(vecs[i].x, vecs[i].w, 1'b1, vecs[i].b);
      idle();
      chk($sformatf("vec%0d_valid", i),  {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_result", i), {16'd0, result}, {16'd0, vecs[i].exp});
      chk($sformatf("vec%0d_busy", i),   {31'd0, in_ready},  32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_onecyc", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("vec%0d_rdy2", i),   {31'd0, in_ready},  32'd1);
    end
    out_ready = 1'b0;

    // Four beats of 1.0 * -1.0.
    for (int i = 0; i < 4; i++) begin
      beat(16'h0100, 16'hFF00, (i == 3), 16'h0000);
      if (i < 3) chk($sformatf("neg4_pending%0d", i), {31'd0, out_valid}, 32'd0);
    end
    idle();
    chk("neg4_valid",   {31'd0, out_valid}, 32'd1);
    chk("neg4_result",  {16'd0, result},    32'h0000FC00);
    chk("neg4_len_err", {31'd0, len_err},   32'd0);
    consume("neg4");

    // Two large products: floored sum 0x7E0200.
    beat(16'h7F00, 16'h7F00, 1'b0, 16'h0000);
    beat(16'h7F00, 16'h7F00, 1'b1, 16'h0000);
    idle();
`ifdef NEURON_MAC_SAT_EN
    chk("sat_result", {16'd0, result}, 32'h00007FFF);
`else
    chk("sat_result", {16'd0, result}, 32'h00000200);
`endif
    consume("sat");

    // Backpressure: beats offered while the result is held must be dropped.
    beat(16'h0100, 16'h0300, 1'b1, 16'h0000);
    in_valid = 1'b1;
    in_x     = 16'h4000;
    in_w     = 16'h4000;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_result%0d", i), {16'd0, result},    32'h00000300);
      chk($sformatf("bp_ready%0d", i),  {31'd0, in_ready},  32'd0);
      chk($sformatf("bp_valid%0d", i),  {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    idle();
    consume("bp");
    beat(16'h0100, 16'h0100, 1'b1, 16'h0000);
    idle();
    chk("bp_next_result", {16'd0, result}, 32'h00000100);
    consume("bp_next");

    // Six beats without in_last: truncated after four, beats 5-6 open a new packet.
    for (int i = 0; i < 4; i++) begin
      beat(16'h0100, 16'h0100, 1'b0, 16'h0000);
    end
    idle();
    chk("ml_valid",   {31'd0, out_valid}, 32'd1);
    chk("ml_result",  {16'd0, result},    32'h00000400);
    chk("ml_len_err", {31'd0, len_err},   32'd1);
    consume("ml");
    for (int i = 0; i < 2; i++) begin
      beat(16'h0100, 16'h0100, 1'b0, 16'h0000);
      chk($sformatf("ml_tail_valid%0d", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("ml_tail_ready%0d", i), {31'd0, in_ready},  32'd1);
    end
    beat(16'h0100, 16'h0100, 1'b1, 16'h0000);
    idle();
    chk("ml_tail_result", {16'd0, result},  32'h00000300);
    chk("ml_sticky",      {31'd0, len_err}, 32'd1);
    consume("ml_tail");
    chk("ml_sticky2",     {31'd0, len_err}, 32'd1);

    // Reset mid-packet clears everything, no partial sum survives.
    beat(16'h0100, 16'h0700, 1'b0, 16'h0000);
    beat(16'h0100, 16'h0700, 1'b0, 16'h0000);
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid",   {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready",   {31'd0, in_ready},  32'd1);
    chk("mid_rst_result",  {16'd0, result},    32'd0);
    chk("mid_rst_len_err", {31'd0, len_err},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    beat(16'h0100, 16'h0100, 1'b1, 16'h0000);
    idle();
    chk("post_rst_result", {16'd0, result}, 32'h00000100);
    chk("post_rst_valid",  {31'd0, out_valid}, 32'd1);
    consume("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
